// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the data memory.
// One outstanding request at a time; completion is signalled by a single-cycle ack.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: converts the EX/MEM register contents into one data-memory
// transaction, steering byte lanes, extending loads and stalling the pipeline until done.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memread_MEM,
  input  logic                      memwrite_MEM,
  input  logic [2:0]                funct3_MEM,
  input  logic [31:0]               alu_out_MEM,
  input  logic [31:0]               rs2_MEM,
  output logic                      stall_MEM,
  output logic [31:0]               load_data_MEM,
  output logic                      load_valid_MEM,
  output logic                      access_err_MEM,
  output logic                      bus_err_MEM,
  mem_access_unit_if.master         dmem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        access, misaligned, funct3_bad, access_bad;
  logic        timeout_hit;
  logic [7:0]  cnt_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  offset_reg;
  logic        is_load_reg;
  logic        req_reg, we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] load_data_reg;
  logic        load_valid_reg, access_err_reg, bus_err_reg;
  logic [31:0] wdata_next;
  logic [3:0]  be_next;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign access = memread_MEM | memwrite_MEM;

  always_comb begin
    misaligned = 1'b0;
    funct3_bad = 1'b0;
    case (funct3_MEM)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = alu_out_MEM[0];
      3'b010:  misaligned = |alu_out_MEM[1:0];
      3'b100:  funct3_bad = memwrite_MEM;
      3'b101: begin
        funct3_bad = memwrite_MEM;
        misaligned = alu_out_MEM[0];
      end
      default: funct3_bad = 1'b1;
    endcase
  end

  assign access_bad  = misaligned | funct3_bad | (memread_MEM & memwrite_MEM);
  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Per-lane store steering: byte stores replicate rs2[7:0], halves replicate rs2[15:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] = (funct3_MEM[1:0] == 2'b10) ? rs2_MEM[8*gi +: 8] :
                                     (funct3_MEM[1:0] == 2'b01) ? rs2_MEM[8*(gi%2) +: 8] :
                                                                  rs2_MEM[7:0];
      assign be_next[gi] = ~memwrite_MEM
                         | (funct3_MEM[1:0] == 2'b10)
                         | ((funct3_MEM[1:0] == 2'b01) & (alu_out_MEM[1] == 1'(gi/2)))
                         | ((funct3_MEM[1:0] == 2'b00) & (alu_out_MEM[1:0] == 2'(gi)));
    end
  endgenerate

  // Extraction uses the width/offset latched at request time, not the live inputs.
  assign rd_byte = dmem.dmem_rdata[{offset_reg, 3'b000} +: 8];
  assign rd_half = dmem.dmem_rdata[{offset_reg[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_reg)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (access) state_next = access_bad ? DONE : BUSY;
      BUSY:    if (dmem.dmem_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_MEM = access & (state_reg != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= 8'd0;
      funct3_reg     <= 3'd0;
      offset_reg     <= 2'd0;
      is_load_reg    <= 1'b0;
      req_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      be_reg         <= 4'd0;
      wdata_reg      <= 32'd0;
      load_data_reg  <= 32'd0;
      load_valid_reg <= 1'b0;
      access_err_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      access_err_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (access && access_bad) begin
            access_err_reg <= 1'b1;
          end else if (access) begin
            req_reg     <= 1'b1;
            we_reg      <= memwrite_MEM;
            addr_reg    <= {alu_out_MEM[31:2], 2'b00};
            be_reg      <= be_next;
            wdata_reg   <= memwrite_MEM ? wdata_next : 32'd0;
            funct3_reg  <= funct3_MEM;
            offset_reg  <= alu_out_MEM[1:0];
            is_load_reg <= memread_MEM;
            cnt_reg     <= 8'd0;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (dmem.dmem_ack) begin
            req_reg        <= 1'b0;
            load_data_reg  <= rd_ext;
            load_valid_reg <= is_load_reg;
          end else if (timeout_hit) begin
            req_reg       <= 1'b0;
            bus_err_reg   <= 1'b1;
            load_data_reg <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = req_reg;
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_be    = be_reg;
  assign dmem.dmem_wdata = wdata_reg;

  assign load_data_MEM  = load_data_reg;
  assign load_valid_MEM = load_valid_reg;
  assign access_err_MEM = access_err_reg;
  assign bus_err_MEM    = bus_err_reg;

endmodule
